// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO for the EX stage.
// Results are computed at launch into pend_*, then committed after a fixed busy window.
module muldiv_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [3:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] Out
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      state_r;
  logic [3:0]  cnt_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;
  logic [31:0] pend_hi_r;
  logic [31:0] pend_lo_r;
  logic        busy_r;

  logic        launch_s;
  logic [31:0] res_hi_s;
  logic [31:0] res_lo_s;
  logic [3:0]  run_len_s;
  logic [63:0] sprod_s;
  logic [63:0] uprod_s;
  logic [31:0] abs_a_s;
  logic [31:0] abs_b_s;
  logic [31:0] mag_q_s;
  logic [31:0] mag_r_s;
  logic [31:0] sdiv_q_s;
  logic [31:0] sdiv_r_s;
  logic [31:0] udiv_q_s;
  logic [31:0] udiv_r_s;
  logic [31:0] safe_b_s;

  assign launch_s = Start && (MDOp >= 4'd1) && (MDOp <= 4'd4);

  // Products and quotients for the operation being launched this cycle
  always_comb begin
    sprod_s  = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    uprod_s  = {32'd0, A} * {32'd0, B};
    // Signed division is done on magnitudes so that 0x80000000 / -1 wraps cleanly.
    abs_a_s  = A[31] ? (32'd0 - A) : A;
    abs_b_s  = B[31] ? (32'd0 - B) : B;
    if (B == 32'd0) begin
      safe_b_s = 32'd1;
      abs_b_s  = 32'd1;
    end else begin
      safe_b_s = B;
    end
    mag_q_s  = abs_a_s / abs_b_s;
    mag_r_s  = abs_a_s % abs_b_s;
    sdiv_q_s = (A[31] ^ B[31]) ? (32'd0 - mag_q_s) : mag_q_s;
    sdiv_r_s = A[31] ? (32'd0 - mag_r_s) : mag_r_s;
    udiv_q_s = A / safe_b_s;
    udiv_r_s = A % safe_b_s;
  end

  // Select the pending result and busy length by operation
  always_comb begin
    res_hi_s  = hi_r;
    res_lo_s  = lo_r;
    run_len_s = 4'(MULT_CYCLES);
    case (MDOp)
      4'd1: begin
        res_hi_s = sprod_s[63:32];
        res_lo_s = sprod_s[31:0];
      end
      4'd2: begin
        res_hi_s = uprod_s[63:32];
        res_lo_s = uprod_s[31:0];
      end
      4'd3: begin
        run_len_s = 4'(DIV_CYCLES);
        if (B != 32'd0) begin
          res_hi_s = sdiv_r_s;
          res_lo_s = sdiv_q_s;
        end else begin
          res_hi_s = hi_r;
          res_lo_s = lo_r;
        end
      end
      4'd4: begin
        run_len_s = 4'(DIV_CYCLES);
        if (B != 32'd0) begin
          res_hi_s = udiv_r_s;
          res_lo_s = udiv_q_s;
        end else begin
          res_hi_s = hi_r;
          res_lo_s = lo_r;
        end
      end
      default: begin
        res_hi_s  = hi_r;
        res_lo_s  = lo_r;
        run_len_s = 4'(MULT_CYCLES);
      end
    endcase
  end

  // Launch/countdown FSM with HI/LO commit and mthi/mtlo writes
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      cnt_r     <= 4'd0;
      hi_r      <= 32'd0;
      lo_r      <= 32'd0;
      pend_hi_r <= 32'd0;
      pend_lo_r <= 32'd0;
      busy_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (launch_s) begin
            pend_hi_r <= res_hi_s;
            pend_lo_r <= res_lo_s;
            cnt_r     <= run_len_s;
            state_r   <= RUN;
            busy_r    <= 1'b1;
          end else if (!Start && MDOp == 4'd5) begin
            hi_r <= A;
          end else if (!Start && MDOp == 4'd6) begin
            lo_r <= A;
          end
        end
        RUN: begin
          cnt_r <= cnt_r - 4'd1;
          if (cnt_r == 4'd1) begin
            hi_r    <= pend_hi_r;
            lo_r    <= pend_lo_r;
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= 4'd0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign Busy = busy_r;

  // mfhi/mflo read port; never sees pending results
  always_comb begin
    case (MDOp)
      4'd7:    Out = hi_r;
      4'd8:    Out = lo_r;
      default: Out = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: timing of Busy, arithmetic, mthi/mtlo, reset.
module tb_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        Start;
  logic [3:0]  MDOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] Out;

  int total;
  int bad;

  muldiv_unit dut (
    .clk   (clk),
    .reset (reset),
    .Start (Start),
    .MDOp  (MDOp),
    .A     (A),
    .B     (B),
    .Busy  (Busy),
    .Out   (Out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Read HI and LO within the current cycle through the Out port
  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    MDOp = 4'd7;
    #1 hi = Out;
    MDOp = 4'd8;
    #1 lo = Out;
    MDOp = 4'd0;
  endtask

  // Launch an op, optionally inject a stray Start at busy-cycle inject_at, count Busy cycles
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int inject_at, output int n);
    Start = 1'b1;
    MDOp  = op;
    A     = a;
    B     = b;
    tick();
    Start = 1'b0;
    MDOp  = 4'd0;
    n = 0;
    while (Busy && n < 50) begin
      n++;
      if (n == inject_at) begin
        Start = 1'b1;
        MDOp  = 4'd3;
        A     = 32'd100;
        B     = 32'd7;
      end
      tick();
      Start = 1'b0;
      MDOp  = 4'd0;
    end
  endtask

  logic [31:0] hi;
  logic [31:0] lo;
  int n;

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    Start = 1'b0;
    MDOp  = 4'd0;
    A     = 32'd0;
    B     = 32'd0;
    tick();
    tick();
    reset = 1'b0;

    read_hilo(hi, lo);
    chk("rst_hi", hi, 32'h0000_0000);
    chk("rst_lo", lo, 32'h0000_0000);
    chk("rst_busy", {31'd0, Busy}, 32'd0);

    run_op(4'd1, 32'hFFFF_FFFE, 32'd3, -1, n);
    chk("mult_busy", 32'(n), 32'd5);
    read_hilo(hi, lo);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);

    run_op(4'd2, 32'hFFFF_FFFE, 32'd3, -1, n);
    chk("multu_busy", 32'(n), 32'd5);
    read_hilo(hi, lo);
    chk("multu_hi", hi, 32'h0000_0002);
    chk("multu_lo", lo, 32'hFFFF_FFFA);

    run_op(4'd3, 32'hFFFF_FFF9, 32'd2, -1, n);
    chk("div_busy", 32'(n), 32'd10);
    read_hilo(hi, lo);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    chk("div_lo", lo, 32'hFFFF_FFFD);

    run_op(4'd4, 32'd7, 32'd0, -1, n);
    chk("divu0_busy", 32'(n), 32'd10);
    read_hilo(hi, lo);
    chk("divu0_hi", hi, 32'hFFFF_FFFF);
    chk("divu0_lo", lo, 32'hFFFF_FFFD);

    run_op(4'd3, 32'd7, 32'hFFFF_FFFE, -1, n);
    read_hilo(hi, lo);
    chk("div_negb_hi", hi, 32'h0000_0001);
    chk("div_negb_lo", lo, 32'hFFFF_FFFD);

    run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, -1, n);
    read_hilo(hi, lo);
    chk("div_ovf_hi", hi, 32'h0000_0000);
    chk("div_ovf_lo", lo, 32'h8000_0000);

    run_op(4'd4, 32'd100, 32'd7, -1, n);
    read_hilo(hi, lo);
    chk("divu_hi", hi, 32'd2);
    chk("divu_lo", lo, 32'd14);

    MDOp = 4'd5;
    A    = 32'h1234_5678;
    tick();
    MDOp = 4'd0;
    read_hilo(hi, lo);
    chk("mthi_hi", hi, 32'h1234_5678);
    chk("mthi_lo", lo, 32'd14);
    chk("mthi_busy", {31'd0, Busy}, 32'd0);

    MDOp = 4'd6;
    A    = 32'hCAFE_0001;
    tick();
    MDOp = 4'd0;
    read_hilo(hi, lo);
    chk("mtlo_hi", hi, 32'h1234_5678);
    chk("mtlo_lo", lo, 32'hCAFE_0001);

    // Stray Start mid-run is ignored; stale HI visible during RUN
    Start = 1'b1;
    MDOp  = 4'd2;
    A     = 32'd3;
    B     = 32'd4;
    tick();
    Start = 1'b0;
    read_hilo(hi, lo);
    chk("stale_hi", hi, 32'h1234_5678);
    chk("stale_lo", lo, 32'hCAFE_0001);
    n = 1;
    while (Busy && n < 50) begin
      if (n == 2) begin
        Start = 1'b1;
        MDOp  = 4'd3;
        A     = 32'd100;
        B     = 32'd7;
      end
      tick();
      Start = 1'b0;
      MDOp  = 4'd0;
      if (Busy) n++;
    end
    chk("inject_busy", 32'(n), 32'd5);
    read_hilo(hi, lo);
    chk("inject_hi", hi, 32'd0);
    chk("inject_lo", lo, 32'd12);

    // Start coinciding with the completing edge is ignored
    run_op(4'd2, 32'd6, 32'd7, 5, n);
    chk("edge_start_busy", 32'(n), 32'd5);
    tick();
    chk("edge_start_idle", {31'd0, Busy}, 32'd0);
    read_hilo(hi, lo);
    chk("edge_start_lo", lo, 32'd42);

    // Reset in cycle T+3 discards the in-flight mult
    Start = 1'b1;
    MDOp  = 4'd1;
    A     = 32'd5;
    B     = 32'd5;
    tick();
    Start = 1'b0;
    MDOp  = 4'd0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_mid_busy", {31'd0, Busy}, 32'd0);
    read_hilo(hi, lo);
    chk("rst_mid_hi", hi, 32'd0);
    chk("rst_mid_lo", lo, 32'd0);
    tick();
    tick();
    read_hilo(hi, lo);
    chk("rst_mid_nowr_lo", lo, 32'd0);
    chk("rst_mid_nowr_busy", {31'd0, Busy}, 32'd0);

    // Back-to-back: div launched in the first idle cycle after a mult
    run_op(4'd2, 32'd2, 32'd3, -1, n);
    chk("b2b_mult_busy", 32'(n), 32'd5);
    run_op(4'd4, 32'd100, 32'd7, -1, n);
    chk("b2b_div_busy", 32'(n), 32'd10);
    read_hilo(hi, lo);
    chk("b2b_hi", hi, 32'd2);
    chk("b2b_lo", lo, 32'd14);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle multiply/divide unit in the EX stage of the five-stage pipeline. It owns the HI/LO registers and executes mult/multu/div/divu/mthi/mtlo. It produces the 32-bit mfhi/mflo value that EX forwards into the MEM pipeline register's MULDIV result field. Busy is exported to the hazard unit, which stalls any MD-class instruction in D while the unit is occupied.

## Interface
- MULT_CYCLES, 5, Busy duration in cycles for mult/multu
- DIV_CYCLES, 10, Busy duration in cycles for div/divu
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- Start  input  1  one-cycle launch pulse, valid only with MDOp 1..4
- MDOp  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo, 9..15 none
- A  input  32  rs operand, already forwarded
- B  input  32  rt operand, already forwarded
- Busy  output  1  high while a mult/div is in flight
- Out  output  32  HI when MDOp=7, LO when MDOp=8, else 0 (combinational)

## Operation
- State: HI, LO (32 each); cnt (4 bits, sized for max(MULT_CYCLES, DIV_CYCLES)); pend_hi, pend_lo (32 each); Busy is registered.
- Two states: IDLE (cnt=0) and RUN (cnt>0). Busy = (state==RUN).
- **IDLE, Start=1, MDOp∈{1..4}:**
  - Compute the result from A and B at that edge into pend_hi/pend_lo.
  - Load cnt with MULT_CYCLES or DIV_CYCLES and enter RUN.
- **RUN:** cnt decrements each edge. On the edge where cnt goes 1→0, HI←pend_hi, LO←pend_lo, return to IDLE.
- **mthi/mtlo (MDOp 5/6, Start=0) in IDLE:** HI←A or LO←A at the edge. No Busy.
- **Ignored inputs:**
  - Start, mthi and mtlo are ignored while Busy=1. The hazard unit guarantees they never arrive then.
  - Start with MDOp outside 1..4 is ignored.
- **Arithmetic:**
  - mult: {HI,LO} = signed(A)×signed(B), 64 bits.
  - multu: {HI,LO} = unsigned 64-bit product.
  - div: LO = quotient truncated toward zero; HI = remainder, carrying the sign of the dividend A.
  - divu: unsigned LO = A/B, HI = A%B.
  - 0x80000000 div 0xFFFFFFFF gives LO=0x80000000, HI=0 (wraps, no trap).
  - B=0 for div/divu: HI/LO are left unchanged on completion. Busy still runs DIV_CYCLES.
- **Out:** pure function of current HI/LO and MDOp. It never reflects pend_*, so mfhi/mflo during RUN read stale values (the hazard unit stalls them).
- **reset (any state, including mid-RUN):** HI=LO=0, pend_*=0, cnt=0, Busy=0. Any in-flight result is discarded.

## Timing
- Reset values: Busy=0, HI=LO=0, so Out=0 for every MDOp.
- Start sampled at edge T.
- **mult/multu:**
  - Busy=1 in cycles T+1..T+5.
  - HI/LO written at edge T+5.
  - Busy=0 from cycle T+6. mfhi in cycle T+6 sees the new HI.
- **div/divu:** Busy=1 in cycles T+1..T+10. HI/LO written at edge T+10.
- **Back-to-back Start:**
  - A new Start is accepted in the first cycle Busy=0. No dead cycle.
  - Start in the same cycle as the completing edge (Busy=1) is ignored.
- mthi/mtlo take effect at the issuing edge. Out in the next cycle reflects the new value.
- Out has zero-cycle latency from MDOp, HI and LO.

## Test plan
- reset, then MDOp=7 and MDOp=8 → Out=0 for both; Busy=0.
- mult A=0xFFFFFFFE (−2), B=3 → Busy high exactly 5 cycles. Afterwards HI=0xFFFFFFFF, LO=0xFFFFFFFA. multu with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- div A=0xFFFFFFF9 (−7), B=2 → Busy high exactly 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=7, B=0 → HI/LO keep their prior values, Busy still 10 cycles.
- mthi A=0x12345678, then mflo/mfhi in the next cycle → Out(mfhi)=0x12345678, LO unchanged. Start asserted while Busy=1 → ignored, completion timing unchanged.
- Start mult (A=5, B=5), then reset at cycle T+3 → Busy=0 next cycle, HI=LO=0, and no write at T+5.
- mult completes, then div is started in the first cycle with Busy=0 → second Busy window begins the next cycle, with no gap beyond that one idle cycle.
